counter_step_arbiter: RTL and testbench

Arbitrates two requesters for shared access to one up/down modulo-N counter. Each requester asks for a direction and a step count. The block sequences the counter's enable and direction inputs for exactly that many enabled cycles, then reports completion and the resulting count. It sits between the control logic and the counter instance, and is the only driver of the counter's enable and direction pins.

---
 rtl/counter_step_arbiter.sv | 134 +++++++++++++
 tb/tb_counter_step_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_step_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_step_arbiter                                                     |
// | Round-robin arbiter sequencing enable/direction of a modulo-N counter.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module counter_step_arbiter #(
  parameter int N      = 6,
  parameter int STEP_W = 8,
  parameter int WIDTH  = (N < 2)   ? 1 :
                         (N < 4)   ? 2 :
                         (N < 8)   ? 3 :
                         (N < 16)  ? 4 :
                         (N < 32)  ? 5 :
                         (N < 64)  ? 6 :
                         (N < 128) ? 7 :
                         (N < 256) ? 8 : 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic              i_req0_dir,
  input  logic [STEP_W-1:0] i_req0_steps,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic              i_req1_dir,
  input  logic [STEP_W-1:0] i_req1_steps,
  output logic              o_req1_ready,
  output logic              o_cnt_en,
  output logic              o_cnt_up_down,
  input  logic [WIDTH-1:0]  i_cnt_q,
  output logic              o_busy,
  output logic              o_grant_id,
  output logic              o_done,
  output logic [WIDTH-1:0]  o_final_q
);

  localparam logic [STEP_W-1:0] c_step_one = STEP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_dir;
  logic              r_id;
  logic              r_last;
  logic              r_up_down;
  logic [STEP_W-1:0] r_remaining;
  logic [WIDTH-1:0]  r_final_q;

  logic              w_win0;
  logic              w_win1;
  logic              w_accept;
  logic              w_sel_dir;
  logic [STEP_W-1:0] w_sel_steps;

  // Under contention the requester that was not granted last time wins.
  always_comb begin
    w_win0 = 1'b0;
    w_win1 = 1'b0;
    if (r_state == ST_IDLE) begin
      if (i_req0_valid && (!i_req1_valid || r_last)) begin
        w_win0 = 1'b1;
      end else if (i_req1_valid) begin
        w_win1 = 1'b1;
      end
    end
  end

  assign w_accept    = w_win0 | w_win1;
  assign w_sel_dir   = w_win1 ? i_req1_dir : i_req0_dir;
  assign w_sel_steps = w_win1 ? i_req1_steps : i_req0_steps;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_sel_steps == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_remaining == c_step_one) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_dir       <= 1'b1;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_up_down   <= 1'b1;
      r_remaining <= '0;
      r_final_q   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_dir       <= w_sel_dir;
        r_remaining <= w_sel_steps;
        r_id        <= w_win1;
        r_last      <= w_win1;
      end
      if (r_state == ST_RUN) begin
        r_remaining <= r_remaining - c_step_one;
        r_up_down   <= r_dir;
      end
      if (r_state == ST_DONE) begin
        r_final_q <= i_cnt_q;
      end
    end
  end

  // Direction pin keeps the last value driven during RUN.
  assign o_cnt_en      = (r_state == ST_RUN);
  assign o_cnt_up_down = (r_state == ST_RUN) ? r_dir : r_up_down;
  assign o_req0_ready  = w_win0;
  assign o_req1_ready  = w_win1;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_grant_id    = r_id;
  assign o_final_q     = r_final_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_step_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_counter_step_arbiter                                                  |
// | Scoreboard bench with a command-level reference model and a mod-N counter.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_counter_step_arbiter;
  localparam int N      = 6;
  localparam int STEP_W = 8;
  localparam int W      = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              v0 = 1'b0, d0 = 1'b0, v1 = 1'b0, d1 = 1'b0;
  logic [STEP_W-1:0] s0 = '0, s1 = '0;
  logic              r0, r1, en, ud, busy, gid, done;
  logic [W-1:0]      cnt_q, fq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int id;
    int cyc;
    int fq;
  } exp_t;
  exp_t sb_q[$];

  counter_step_arbiter #(.N(N), .STEP_W(STEP_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_dir(d0), .i_req0_steps(s0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_dir(d1), .i_req1_steps(s1), .o_req1_ready(r1),
    .o_cnt_en(en), .o_cnt_up_down(ud), .i_cnt_q(cnt_q),
    .o_busy(busy), .o_grant_id(gid), .o_done(done), .o_final_q(fq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: the controlled modulo-N up/down counter.
  always @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (en) begin
      if (ud) cnt_q <= (cnt_q == W'(N - 1)) ? '0 : cnt_q + 1'b1;
      else    cnt_q <= (cnt_q == '0) ? W'(N - 1) : cnt_q - 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: command-level view of arbitration and timing.
  bit m_active = 0;
  int m_k = 0, m_steps = 0, m_dir = 1, m_ptr = 1, m_cnt = 0, m_ud = 1;
  always @(negedge clk) begin
    bit e0, e1;
    int en_exp, ud_exp;
    if (rst) begin
      m_active = 0; m_ptr = 1; m_cnt = 0; m_ud = 1;
      sb_q.delete();
    end else begin
      e0 = !m_active && v0 && (!v1 || m_ptr == 1);
      e1 = !m_active && v1 && !e0;
      chk("ready0", r0, int'(e0));
      chk("ready1", r1, int'(e1));
      chk("busy", busy, int'(m_active));
      en_exp = (m_active && m_k <= m_steps) ? 1 : 0;
      chk("cnt_en", en, en_exp);
      ud_exp = en_exp ? m_dir : m_ud;
      chk("up_down", ud, ud_exp);
      if (en_exp != 0) m_ud = m_dir;
      if (m_active) begin
        if (m_k == m_steps + 1) m_active = 0;
        else m_k++;
      end
      if (e0 || e1) begin
        m_active = 1;
        m_k      = 1;
        m_ptr    = int'(e1);
        m_dir    = e1 ? int'(d1) : int'(d0);
        m_steps  = e1 ? int'(s1) : int'(s0);
        m_cnt    = ((m_cnt + (m_dir != 0 ? m_steps : -m_steps)) % N + N) % N;
        sb_q.push_back('{id: int'(e1), cyc: cyc + m_steps + 1, fq: m_cnt});
      end
    end
  end

  // Monitor: pops an expectation for every completion pulse.
  bit fq_pending = 0;
  int fq_exp = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      fq_pending = 0;
    end else begin
      if (fq_pending) begin
        chk("final_q", fq, fq_exp);
        fq_pending = 0;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got done=1 expected no pending command (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("grant_id", gid, e.id);
          chk("done_cycle", cyc, e.cyc);
          fq_exp = e.fq;
          fq_pending = 1;
        end
      end
    end
  end

  task automatic send(input int id, input bit dir, input int steps);
    int t = 0;
    @(posedge clk); #1;
    if (id == 0) begin v0 = 1'b1; d0 = dir; s0 = STEP_W'(steps); end
    else         begin v1 = 1'b1; d1 = dir; s1 = STEP_W'(steps); end
    forever begin
      @(negedge clk);
      if (((id == 0) ? r0 : r1) === 1'b1) break;
      t++;
      if (t > 3000) begin
        n_checks++; n_fail++;
        $display("FAIL handshake_timeout: got no ready expected ready for req%0d", id);
        break;
      end
    end
    @(posedge clk); #1;
    if (id == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cnt_en", en, 0);
    chk("rst_up_down", ud, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grant_id", gid, 0);
    chk("rst_final_q", fq, 0);

    send(0, 1'b1, 4);                    // single command up
    idle(8);

    do_reset();                          // contention rounds
    for (int r = 0; r < 4; r++) begin
      fork
        send(0, 1'b1, 2);
        send(1, 1'b0, 2);
      join
      idle(5);
    end

    send(1, 1'b0, 0);                    // zero steps
    idle(4);

    do_reset();                          // down through wrap
    send(0, 1'b1, 1);
    idle(4);
    send(0, 1'b0, 3);
    idle(6);

    send(0, 1'b1, 10);                   // reset in enabled cycle 5
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_cnt_en", en, 0);
    chk("abort_final_q", fq, 0);
    fork
      send(1, 1'b1, 1);
      send(0, 1'b1, 1);
    join
    idle(5);

    fork                                 // maximum steps with waiting requester
      send(0, 1'b1, 255);
      begin idle(3); send(1, 1'b0, 2); end
    join
    idle(6);

    for (int p = 0; p < 2; p++) begin    // randomized traffic
      fork
        for (int i = 0; i < 30; i++) begin
          idle($urandom_range(0, 3));
          send(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12));
        end
        for (int i = 0; i < 30; i++) begin
          idle($urandom_range(0, 3));
          send(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12));
        end
      join
    end
    idle(20);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
